// File: rtl/distribution_reader.sv
// Streams every lattice node of distribution_ram in row-major order to the
// collision/stream pipeline, tagging each word with its (x, y) coordinate.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing one RAM read per cycle while the 2-entry buffer has room
// DRAIN  | final read issued; emptying the buffer to the consumer
// DONE   | one-cycle completion pulse
module distribution_reader #(
    parameter int GRID_X        = 16,
    parameter int GRID_Y        = 16,
    parameter int DEPTH         = GRID_X * GRID_Y,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 32 * 9,
    parameter int X_WIDTH       = $clog2(GRID_X),
    parameter int Y_WIDTH       = $clog2(GRID_Y)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     WE,
    input  logic [DATA_WIDTH-1:0]    data_out,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [X_WIDTH-1:0]       out_x,
    output logic [Y_WIDTH-1:0]       out_y,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [X_WIDTH-1:0]       X_MAX     = X_WIDTH'(GRID_X - 1);
    localparam logic [Y_WIDTH-1:0]       Y_MAX     = Y_WIDTH'(GRID_Y - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_issue;
    logic                     w_xfer;
    logic [2:0]               w_level;

    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [X_WIDTH-1:0]       r_iss_x;
    logic [Y_WIDTH-1:0]       r_iss_y;

    logic                     r_inflight;
    logic [X_WIDTH-1:0]       r_inf_x;
    logic [Y_WIDTH-1:0]       r_inf_y;
    logic                     r_inf_last;

    logic [DATA_WIDTH-1:0]    r_ent_data [2];
    logic [X_WIDTH-1:0]       r_ent_x    [2];
    logic [Y_WIDTH-1:0]       r_ent_y    [2];
    logic                     r_ent_last [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;

    assign WE        = 1'b0;
    assign address   = r_address;
    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_ent_data[r_rd_ptr];
    assign out_x     = r_ent_x[r_rd_ptr];
    assign out_y     = r_ent_y[r_rd_ptr];
    assign out_last  = r_ent_last[r_rd_ptr];

    assign w_xfer    = out_valid & out_ready;

    // Words that will occupy the buffer next cycle if nothing new is issued.
    assign w_level   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (w_level < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_address == LAST_ADDR) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_xfer && out_last && !r_inflight && (r_count == 2'd1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_address <= '0;
            r_iss_x   <= '0;
            r_iss_y   <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_address <= '0;
            r_iss_x   <= '0;
            r_iss_y   <= '0;
        end else if (w_issue) begin
            r_address <= r_address + ADDRESS_WIDTH'(1);
            if (r_iss_x == X_MAX) begin
                r_iss_x <= '0;
                r_iss_y <= (r_iss_y == Y_MAX) ? '0 : r_iss_y + Y_WIDTH'(1);
            end else begin
                r_iss_x <= r_iss_x + X_WIDTH'(1);
            end
        end
    end

    // Tag of the read the RAM is answering this cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_inflight <= 1'b0;
            r_inf_x    <= '0;
            r_inf_y    <= '0;
            r_inf_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_inf_x    <= r_iss_x;
            r_inf_y    <= r_iss_y;
            r_inf_last <= (r_address == LAST_ADDR);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                r_ent_data[i] <= '0;
                r_ent_x[i]    <= '0;
                r_ent_y[i]    <= '0;
                r_ent_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_ent_data[r_wr_ptr] <= data_out;
                r_ent_x[r_wr_ptr]    <= r_inf_x;
                r_ent_y[r_wr_ptr]    <= r_inf_y;
                r_ent_last[r_wr_ptr] <= r_inf_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_xfer) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
        end
    end

endmodule

// File: doc/distribution_reader.md
# distribution_reader

Streaming read controller for `distribution_ram`.
- On `start`, sweeps every lattice node of the GRID_X × GRID_Y D2Q9 grid in row-major order and reads its nine packed 32-bit distributions.
- Presents each node word, with its (x, y) coordinate, to the downstream collision/stream pipeline over a valid/ready handshake.
- Absorbs the RAM's one-cycle read latency and downstream backpressure with a 2-entry buffer, so no word is lost or duplicated.

## Interface
Parameters:
- GRID_X, 16, lattice width in nodes
- GRID_Y, 16, lattice height in nodes
- DEPTH, GRID_X*GRID_Y, node count (RAM depth)
- ADDRESS_WIDTH, $clog2(DEPTH), RAM address width
- DATA_WIDTH, 32*9, packed signed distribution word (f0 in bits [31:0] … f8 in bits [287:256])

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final transfer
- address  out  ADDRESS_WIDTH  RAM read address
- WE  out  1  RAM write enable; constant 0
- data_out  in  DATA_WIDTH  RAM read data; valid the cycle after `address` is sampled
- out_data  out  DATA_WIDTH  node distributions
- out_x  out  $clog2(GRID_X)  node x = addr % GRID_X
- out_y  out  $clog2(GRID_Y)  node y = addr / GRID_X
- out_last  out  1  high with the word for address DEPTH-1
- out_valid  out  1  out_* holds a valid node
- out_ready  in  1  downstream accepts; transfer = out_valid & out_ready

## Operation
States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `busy` = 0.
  - `start` = 1 → READ; `address` cleared to 0; issue counter cleared.
- READ:
  - A read is issued in a cycle when (buffer occupancy + in-flight − transfer this cycle) < 2.
  - On issue: `address` increments on the next edge, and the in-flight flag is set for one cycle.
  - After the read of address DEPTH-1 is issued → DRAIN.
- DRAIN:
  - No new issues.
  - When the buffer is empty, nothing is in flight, and the last word (`out_last`) has transferred → DONE.
- DONE:
  - `done` = 1 for exactly one cycle, `busy` = 0 in that cycle.
  - Always → IDLE.
- Buffer:
  - 2-entry FIFO of {data, x, y, last}. The head drives out_*.
  - A returning RAM word is written in the cycle it arrives.
  - Overflow is impossible by the issue rule; the bench checks it by assertion.
- Coordinates:
  - Tracked per entry, computed from the issued address: x counter wraps at GRID_X-1 and increments y.
  - y never exceeds GRID_Y-1.
- `start` in any state other than IDLE is ignored.
- `start` held high continuously restarts the sweep in the cycle after DONE, i.e. when back in IDLE.
- Output stability: while out_valid & !out_ready, all out_* hold their values.
- Data is passed unmodified; no arithmetic is performed on the distributions.

## Timing
- Reset (asynchronous, any state, including mid-sweep): state IDLE, address 0, WE 0, busy 0, done 0, out_valid 0, out_last 0, out_data/out_x/out_y 0, buffer emptied. A read in flight is discarded.
- start sampled high at edge E0 → busy and address 0 from E0.
- RAM samples address 0 at E1; the word is captured at E2; out_valid = 1 from E2. Latency from start edge to first valid = 2 cycles.
- With out_ready held high: one transfer per cycle.
  - Node n transfers at edge E(3+n).
  - The last transfer (n = 255) occurs at E258.
  - done is high during the cycle following E258; busy falls at E258.
- out_ready low: at most 2 words are buffered, then issue stalls. `address` holds its value while stalled.
- When ready rises, transfers resume in that same cycle from the buffer head. Issue resumes so that there is no bubble after the first cycle.

## Test plan
- Full sweep, ready high: preload RAM word = {9 × addr} → 256 transfers in order; out_x/out_y match (addr%16, addr/16); out_last only on addr 255; exactly one done pulse; first out_valid 2 cycles after start.
- Backpressure: out_ready low for cycles 5–14 of the sweep → out_* stable throughout; no word lost or duplicated; buffer never exceeds 2; address frozen.
- Random out_ready (50 %) → received sequence equals 0..255 exactly; done occurs after the final transfer only.
- start pulsed at node 100 during a sweep → ignored; no restart; single done.
- Reset asserted mid-sweep at node 50 → all outputs 0 immediately (asynchronous); a new start produces a clean sweep from address 0.
- start held high → two back-to-back sweeps; the second begins in the cycle after done; WE = 0 at all times.
